// File: rtl/trace_emitter.sv
// trace_emitter: classifies retiring instructions into trace records and
// queues them in a 4-entry FIFO with a valid/ready consumer interface.
// Optional feature macro: TRACE_CYCLE_STAMP_EN adds a per-record cycle stamp
// (rec_cycle) taken from a free-running counter at capture time.
module trace_emitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_valid,
  input  logic [15:0] retire_pc,
  input  logic        reg_write,
  input  logic [3:0]  wr_reg,
  input  logic [15:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  input  logic        rec_ready,
  output logic        rec_valid,
  output logic [2:0]  rec_kind,
  output logic [31:0] rec_inum,
  output logic [15:0] rec_pc,
  output logic [3:0]  rec_reg,
  output logic [15:0] rec_value,
  output logic [15:0] rec_addr,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [31:0] rec_cycle,
`endif
  output logic        stall,
  output logic        overflow,
  output logic        done
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] K_ALU   = 3'd0;
  localparam logic [2:0] K_LOAD  = 3'd1;
  localparam logic [2:0] K_STORE = 3'd2;
  localparam logic [2:0] K_OTHER = 3'd3;
  localparam logic [2:0] K_HALT  = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rreg;
    logic [15:0] value;
    logic [15:0] addr;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cycle;
`endif
  } rec_t;

  logic [1:0]      state_q, state_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [31:0]     inum_q, inum_d;
  logic            ovf_q, ovf_d;
  rec_t [3:0]      mem_q, mem_d;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0]     cyc_q, cyc_d;
`endif

  rec_t new_rec, head;
  logic cap, push, pop, full;

  assign head = mem_q[rd_ptr_q];

  // Build the incoming record, decide push/pop/drop and advance the FSM.
  always_comb begin
    new_rec      = '0;
    new_rec.inum = inum_q;
    new_rec.pc   = retire_pc;
`ifdef TRACE_CYCLE_STAMP_EN
    new_rec.cycle = cyc_q;
`endif
    if (reg_write && mem_read) begin
      new_rec.kind  = K_LOAD;
      new_rec.rreg  = wr_reg;
      new_rec.value = wr_data;
      new_rec.addr  = mem_addr;
    end else if (reg_write) begin
      new_rec.kind  = K_ALU;
      new_rec.rreg  = wr_reg;
      new_rec.value = wr_data;
    end else if (halt) begin
      new_rec.kind  = K_HALT;
    end else if (mem_write) begin
      new_rec.kind  = K_STORE;
      new_rec.value = mem_data;
      new_rec.addr  = mem_addr;
    end else begin
      new_rec.kind  = K_OTHER;
    end

    full = (cnt_q == 3'd4);
    pop  = (cnt_q != 3'd0) && rec_ready;
    cap  = retire_valid && (state_q == RUN);
    // A full FIFO still takes a record when the head leaves on the same edge.
    push = cap && (!full || pop);

    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    inum_d   = inum_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
`ifdef TRACE_CYCLE_STAMP_EN
    cyc_d    = cyc_q + 32'd1;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = new_rec;
      wr_ptr_d        = wr_ptr_q + 2'd1;
      inum_d          = inum_q + 32'd1;
    end
    if (cap && !push) ovf_d = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};

    case (state_q)
      RUN:     if (push && new_rec.kind == K_HALT) state_d = DRAIN;
      DRAIN:   if (pop && head.kind == K_HALT)     state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  // Control state: synchronous active-low reset clears queue and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      inum_q   <= 32'd0;
      ovf_q    <= 1'b0;
`ifdef TRACE_CYCLE_STAMP_EN
      cyc_q    <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      inum_q   <= inum_d;
      ovf_q    <= ovf_d;
`ifdef TRACE_CYCLE_STAMP_EN
      cyc_q    <= cyc_d;
`endif
    end
  end

  // Record storage carries no reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rec_valid = (cnt_q != 3'd0);
  assign rec_kind  = rec_valid ? head.kind  : 3'd0;
  assign rec_inum  = rec_valid ? head.inum  : 32'd0;
  assign rec_pc    = rec_valid ? head.pc    : 16'd0;
  assign rec_reg   = rec_valid ? head.rreg  : 4'd0;
  assign rec_value = rec_valid ? head.value : 16'd0;
  assign rec_addr  = rec_valid ? head.addr  : 16'd0;
`ifdef TRACE_CYCLE_STAMP_EN
  assign rec_cycle = rec_valid ? head.cycle : 32'd0;
`endif
  assign stall     = (cnt_q == 3'd4);
  assign overflow  = ovf_q;
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_trace_emitter.sv
// Scoreboard bench for trace_emitter: a queue-based reference model predicts
// accepted records; a negedge monitor compares every handshake and status.
module tb_trace_emitter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        retire_valid = 1'b0;
  logic [15:0] retire_pc = '0;
  logic        reg_write = 1'b0;
  logic [3:0]  wr_reg = '0;
  logic [15:0] wr_data = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] mem_addr = '0, mem_data = '0;
  logic        halt = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [2:0]  rec_kind;
  logic [31:0] rec_inum;
  logic [15:0] rec_pc;
  logic [3:0]  rec_reg;
  logic [15:0] rec_value, rec_addr;
  logic        stall, overflow, done;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] rec_cycle;
`endif

  trace_emitter dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .halt(halt), .rec_ready(rec_ready),
    .rec_valid(rec_valid), .rec_kind(rec_kind), .rec_inum(rec_inum),
    .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_value(rec_value),
    .rec_addr(rec_addr),
`ifdef TRACE_CYCLE_STAMP_EN
    .rec_cycle(rec_cycle),
`endif
    .stall(stall), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] value;
    logic [15:0] addr;
    logic [31:0] cyc;
  } rec_t;

  // Reference model: FIFO contents as a queue of kinds, expected records in exp_q.
  rec_t        exp_q[$];
  logic [2:0]  mk[$];
  int          mst = 0;          // 0 running, 1 draining, 2 done
  logic [31:0] minum = 0;
  logic [31:0] mcyc = 0;
  bit          movf = 0;
  bit          fresh = 1;
  bit          started = 0;
  int          tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t classify();
    rec_t r;
    r = '{default: '0};
    r.pc = retire_pc;
    if (reg_write && mem_read) begin r.kind = 1; r.rg = wr_reg; r.value = wr_data; r.addr = mem_addr; end
    else if (reg_write)        begin r.kind = 0; r.rg = wr_reg; r.value = wr_data; end
    else if (halt)             r.kind = 4;
    else if (mem_write)        begin r.kind = 2; r.value = mem_data; r.addr = mem_addr; end
    else                       r.kind = 3;
    return r;
  endfunction

  always @(posedge clk) begin
    rec_t r;
    bit   pop;
    logic [2:0] hk;
    started = 1;
    if (!rst) begin
      exp_q.delete(); mk.delete();
      mst = 0; minum = 0; mcyc = 0; movf = 0; fresh = 1;
    end else begin
      pop = (mk.size() > 0) && rec_ready;
      if (retire_valid && mst == 0) begin
        if (mk.size() < 4 || pop) begin
          r = classify();
          r.inum = minum;
          r.cyc = mcyc;
          exp_q.push_back(r);
          mk.push_back(r.kind);
          minum++;
          fresh = 0;
          if (r.kind == 4) mst = 1;
        end else movf = 1;
      end
      if (pop) begin
        hk = mk.pop_front();
        if (hk == 4 && mst == 1) mst = 2;
      end
      mcyc++;
    end
  end

  // Monitor: status every cycle; record fields on each handshake.
  always @(negedge clk) begin
    rec_t e;
    if (started) begin
      chk("rec_valid", {31'd0, rec_valid}, {31'd0, mk.size() > 0});
      chk("stall", {31'd0, stall}, {31'd0, mk.size() == 4});
      chk("overflow", {31'd0, overflow}, {31'd0, movf});
      chk("done", {31'd0, done}, {31'd0, mst == 2});
      if (fresh)
        chk("idle_data_zero", {29'd0, rec_kind} | rec_inum | {16'd0, rec_pc} |
            {28'd0, rec_reg} | {16'd0, rec_value} | {16'd0, rec_addr}, 32'd0);
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) chk("unexpected_record", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("kind", {29'd0, rec_kind}, {29'd0, e.kind});
          chk("inum", rec_inum, e.inum);
          chk("pc", {16'd0, rec_pc}, {16'd0, e.pc});
          chk("reg", {28'd0, rec_reg}, {28'd0, e.rg});
          chk("value", {16'd0, rec_value}, {16'd0, e.value});
          chk("addr", {16'd0, rec_addr}, {16'd0, e.addr});
`ifdef TRACE_CYCLE_STAMP_EN
          chk("cycle", rec_cycle, e.cyc);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ret(input bit rw, input bit mr, input bit mw, input bit h,
                     input logic [15:0] pc, input logic [3:0] r, input logic [15:0] d,
                     input logic [15:0] a, input logic [15:0] md);
    retire_valid = 1; reg_write = rw; mem_read = mr; mem_write = mw; halt = h;
    retire_pc = pc; wr_reg = r; wr_data = d; mem_addr = a; mem_data = md;
    tick();
    retire_valid = 0;
  endtask

  task automatic do_reset();
    rst = 0; tick(); tick(); rst = 1;
  endtask

  task automatic drain();
    int n = 0;
    rec_ready = 1;
    while (mk.size() > 0 && n < 50) begin tick(); n++; end
    chk("drain_timeout", {31'd0, mk.size() > 0}, 32'd0);
  endtask

  initial begin
    do_reset();
    // Single ALU record
    rec_ready = 1;
    ret(1, 0, 0, 0, 16'h0000, 4'd3, 16'h0005, 16'h0, 16'h0);
    tick(); tick();
    // LOAD then STORE
    ret(1, 1, 0, 0, 16'h0001, 4'd2, 16'hBEEF, 16'h0010, 16'h0);
    ret(0, 0, 1, 0, 16'h0002, 4'd0, 16'h0, 16'h0020, 16'h1234);
    tick(); tick(); tick();
    // Fill, stall, drop one, drain
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 5; i++) ret(1, 0, 0, 0, 16'(16'h10 + i), 4'(i), 16'(i * 3), 16'h0, 16'h0);
    tick();
    drain();
    ret(1, 0, 0, 0, 16'h0100, 4'd7, 16'h7777, 16'h0, 16'h0);
    tick(); tick();
    // Full FIFO with simultaneous pop
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 4; i++) ret(1, 0, 0, 0, 16'(16'h20 + i), 4'(i), 16'(i), 16'h0, 16'h0);
    rec_ready = 1;
    ret(0, 0, 1, 0, 16'h0030, 4'd0, 16'h0, 16'h0044, 16'h5555);
    rec_ready = 0; tick();
    drain();
    // OTHER, HALT, then ignored retires
    do_reset();
    rec_ready = 1;
    ret(0, 0, 0, 0, 16'h0040, 4'd0, 16'h0, 16'h0, 16'h0);
    ret(0, 0, 0, 1, 16'h0041, 4'd0, 16'h0, 16'h0, 16'h0);
    ret(1, 0, 0, 0, 16'h0042, 4'd1, 16'h0001, 16'h0, 16'h0);
    ret(1, 0, 0, 0, 16'h0043, 4'd1, 16'h0002, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) tick();
    rec_ready = 0;
    ret(1, 0, 0, 0, 16'h0044, 4'd1, 16'h0003, 16'h0, 16'h0);
    tick();
    // Reset with queued records
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 3; i++) ret(0, 0, 0, 1 - (i < 2), 16'(16'h50 + i), 4'd0, 16'h0, 16'h0, 16'h0);
    do_reset();
    tick();
    rec_ready = 1;
    ret(1, 0, 0, 0, 16'h0060, 4'd9, 16'h0909, 16'h0, 16'h0);
    tick(); tick();
    // Randomized episodes
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        rec_ready = ($urandom % 4) != 0;
        if (($urandom % 2 == 0) && (!stall || $urandom % 8 == 0))
          ret($urandom % 2 == 0, $urandom % 2 == 0, $urandom % 2 == 0, $urandom % 60 == 0,
              16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        else tick();
      end
      drain();
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
